// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter sharing one message disassembler between NUM_SRC sources.
// Captures the winning message, launches it, holds it until the disassembler reports idle again.
module msg_tx_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int MSG_WIDTH = 32,
    localparam int ID_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic [NUM_SRC-1:0]           req,
    input  logic [NUM_SRC*MSG_WIDTH-1:0] msg_in,
    output logic [NUM_SRC-1:0]           ack,
    output logic [MSG_WIDTH-1:0]         dis_data,
    output logic                         dis_valid,
    input  logic                         dis_ready,
    output logic                         done,
    output logic [ID_WIDTH-1:0]          cur_src,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_TX, WAIT_DONE} state_t;

    state_t               state, state_nxt;
    logic [ID_WIDTH-1:0]  ptr, winner, ptr_nxt;
    logic [MSG_WIDTH-1:0] msg_buf;
    logic                 found, grant, done_set;
    int                   idx;

    // Walk downward so the index closest to ptr (k=0) is the last, winning assignment.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC)
                idx = idx - NUM_SRC;
            if (req[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    assign ptr_nxt = (winner == ID_WIDTH'(NUM_SRC - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (found && dis_ready) begin
                    grant     = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:    state_nxt = WAIT_TX;
            WAIT_TX:   if (!dis_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (dis_ready) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_src <= '0;
            msg_buf <= '0;
            ack     <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= '0;
            done  <= done_set;
            if (grant) begin
                msg_buf     <= msg_in[int'(winner)*MSG_WIDTH +: MSG_WIDTH];
                cur_src     <= winner;
                ack[winner] <= 1'b1;
                ptr         <= ptr_nxt;
            end
        end
    end

    assign dis_data  = msg_buf;
    assign dis_valid = (state == LAUNCH);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Self-checking bench for msg_tx_arbiter: a 4-source instance driving a byte-serial
// disassembler model, plus a 3-source instance for pointer wrap checks.
module tb_msg_tx_arbiter;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] msg_in = '0;
    logic [3:0]   ack;
    logic [31:0]  dis_data;
    logic         dis_valid, dis_ready, done, busy;
    logic [1:0]   cur_src;

    logic [2:0]   req3 = '0;
    logic [95:0]  msg3 = '0;
    logic [2:0]   ack3;
    logic [31:0]  data3;
    logic         valid3, ready3, done3, busy3;
    logic [1:0]   cur3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    msg_tx_arbiter #(.NUM_SRC(4), .MSG_WIDTH(32)) dut (
        .clk(clk), .n_reset(n_reset), .req(req), .msg_in(msg_in), .ack(ack),
        .dis_data(dis_data), .dis_valid(dis_valid), .dis_ready(dis_ready),
        .done(done), .cur_src(cur_src), .busy(busy)
    );

    msg_tx_arbiter #(.NUM_SRC(3), .MSG_WIDTH(32)) dut3 (
        .clk(clk), .n_reset(n_reset), .req(req3), .msg_in(msg3), .ack(ack3),
        .dis_data(data3), .dis_valid(valid3), .dis_ready(ready3),
        .done(done3), .cur_src(cur3), .busy(busy3)
    );

    // 4-byte disassembler model: accepts on dis_valid, emits LSB first while uart_ready.
    logic       m_busy = 1'b0;
    logic [1:0] m_cnt = '0;
    logic [31:0] m_sh = '0;
    logic       hold_busy = 1'b0;
    logic       uart_ready = 1'b1;
    int         uart_mode = 0;
    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];

    assign dis_ready = !m_busy && !hold_busy;

    always @(posedge clk) begin
        if (!n_reset) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (!m_busy) begin
            if (dis_valid && dis_ready) begin
                m_busy <= 1'b1;
                m_sh   <= dis_data;
                m_cnt  <= '0;
            end
        end else if (uart_ready) begin
            got_bytes.push_back(m_sh[8*m_cnt +: 8]);
            m_cnt <= m_cnt + 2'd1;
            if (m_cnt == 2'd3) m_busy <= 1'b0;
        end
    end

    always @(negedge clk)
        uart_ready <= (uart_mode == 0) ? 1'b1 : (uart_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    // Minimal disassembler for the 3-source instance: busy for two cycles after launch.
    logic [1:0] b3 = '0;
    assign ready3 = (b3 == 2'd0);
    always @(posedge clk) begin
        if (!n_reset)    b3 <= '0;
        else if (valid3) b3 <= 2'd2;
        else if (b3 != 0) b3 <= b3 - 2'd1;
    end

    task automatic push_msg(input logic [31:0] m);
        for (int b = 0; b < 4; b++) exp_bytes.push_back(m[8*b +: 8]);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        got_bytes.delete();
        exp_bytes.delete();
    endtask

    task automatic wait_ack(input string nm);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ack != 0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no ack within 100 cycles, required an ack", nm);
        end
    endtask

    task automatic wait_ack3(input string nm);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ack3 != 0) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no ack within 100 cycles, required an ack", nm);
        end
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no done within 300 cycles, required a done pulse", nm);
        end
    endtask

    task automatic check_bytes(input string nm);
        n_checks++;
        if (got_bytes.size() != exp_bytes.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d bytes, required %0d", nm, got_bytes.size(), exp_bytes.size());
        end else begin
            for (int i = 0; i < exp_bytes.size(); i++) begin
                n_checks++;
                if (got_bytes[i] !== exp_bytes[i]) begin
                    n_fail++;
                    $display("FAIL %s byte %0d: got %h, required %h", nm, i, got_bytes[i], exp_bytes[i]);
                end
            end
        end
        got_bytes.delete();
        exp_bytes.delete();
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        req     = 4'b1111;
        req3    = 3'b111;
        msg_in  = {4{32'hDEADBEEF}};
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, done, dis_valid, busy, cur_src} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack=%b done=%b valid=%b busy=%b cur=%0d, required all 0",
                     ack, done, dis_valid, busy, cur_src);
        end
        n_checks++;
        if (dis_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", dis_data);
        end
        n_checks++;
        if ({ack3, done3, valid3, busy3} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_3src: got ack=%b done=%b valid=%b busy=%b, required all 0",
                     ack3, done3, valid3, busy3);
        end
        req  = '0;
        req3 = '0;
        n_reset = 1'b1;
        got_bytes.delete();
    endtask

    task automatic test_single;
        apply_reset();
        uart_mode = 0;
        msg_in[64 +: 32] = 32'hA1B2C3D4;
        push_msg(32'hA1B2C3D4);
        req = 4'b0100;
        wait_ack("single_ack");
        n_checks++;
        if ({ack, dis_valid, busy, cur_src} !== {4'b0100, 1'b1, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL single_grant: got ack=%b valid=%b busy=%b cur=%0d, required 0100 1 1 2",
                     ack, dis_valid, busy, cur_src);
        end
        n_checks++;
        if (dis_data !== 32'hA1B2C3D4) begin
            n_fail++;
            $display("FAIL single_data: got %h, required a1b2c3d4", dis_data);
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if ({ack, dis_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_pulse: got ack=%b valid=%b, required 0 0", ack, dis_valid);
        end
        wait_done("single_done");
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_at_done: got %b, required 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: got %b, required 0", done);
        end
        check_bytes("single_bytes");
    endtask

    task automatic test_round_robin;
        int e;
        apply_reset();
        for (int i = 0; i < 4; i++) msg_in[32*i +: 32] = 32'hC0DE0000 | (32'h0101 * (i + 1));
        for (int g = 0; g < 5; g++) push_msg(msg_in[32*(g%4) +: 32]);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e = g % 4;
            wait_ack("rr_ack");
            n_checks++;
            if (ack !== 4'(1 << e) || cur_src !== 2'(e)) begin
                n_fail++;
                $display("FAIL rr_order %0d: got ack=%b cur=%0d, required src %0d", g, ack, cur_src, e);
            end
            n_checks++;
            if (dis_data !== msg_in[32*e +: 32]) begin
                n_fail++;
                $display("FAIL rr_data %0d: got %h, required %h", g, dis_data, msg_in[32*e +: 32]);
            end
            @(negedge clk);
            n_checks++;
            if (ack !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_ack_width %0d: got %b, required 0000", g, ack);
            end
        end
        req = '0;
        wait_done("rr_done");
        check_bytes("rr_bytes");
    endtask

    task automatic test_hold;
        int bad = 0;
        bit seen = 0;
        uart_mode = 1;
        msg_in[32 +: 32] = 32'h5A6B7C8D;
        push_msg(32'h5A6B7C8D);
        req = 4'b0010;
        wait_ack("hold_ack");
        msg_in[32 +: 32] = 32'hFFFF0000;
        req = '0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (dis_data !== 32'h5A6B7C8D) bad++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen || bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles (done seen=%0d), required 0 and done", bad, seen);
        end
        uart_mode = 0;
        check_bytes("hold_bytes");
    endtask

    task automatic test_wrap;
        apply_reset();
        msg3 = {32'h22222222, 32'h11111111, 32'h00000000};
        req3 = 3'b100;
        wait_ack3("wrap_ack2");
        n_checks++;
        if (ack3 !== 3'b100) begin
            n_fail++;
            $display("FAIL wrap_first: got ack=%b, required 100", ack3);
        end
        @(negedge clk);
        req3 = 3'b101;
        wait_ack3("wrap_ack0");
        n_checks++;
        if (ack3 !== 3'b001 || cur3 !== 2'd0 || data3 !== 32'h00000000) begin
            n_fail++;
            $display("FAIL wrap_to0: got ack=%b cur=%0d data=%h, required 001 0 00000000", ack3, cur3, data3);
        end
        req3 = 3'b100;
        wait_ack3("wrap_ack2b");
        n_checks++;
        if (ack3 !== 3'b100 || cur3 !== 2'd2 || data3 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL wrap_skip1: got ack=%b cur=%0d data=%h, required 100 2 22222222", ack3, cur3, data3);
        end
        req3 = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_busy_reset;
        apply_reset();
        uart_mode = 2;
        hold_busy = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack !== 4'b0) begin
                n_fail++;
                $display("FAIL busy_no_grant %0d: got ack=%b, required 0000", i, ack);
            end
        end
        hold_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL busy_release: got ack=%b, required 0001", ack);
        end
        req = '0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_tx: got %b, required 1", busy);
        end
        n_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, ack, cur_src} !== 8'b0 || dis_data !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: got done=%b busy=%b ack=%b cur=%0d data=%h, required all 0",
                     done, busy, ack, cur_src, dis_data);
        end
        n_reset = 1'b1;
        uart_mode = 0;
        req = 4'b1001;
        wait_ack("ptr_after_reset");
        n_checks++;
        if (ack !== 4'b0001 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ptr_reset: got ack=%b done=%b, required 0001 0", ack, done);
        end
        req = '0;
        wait_done("busy_final_done");
        got_bytes.delete();
        exp_bytes.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_wrap();
        test_busy_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
